// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with wrap/saturate limits, overflow/underflow pulses and a sticky flag.
// Optional tick prescaler is built when CNT_PRESCALE_EN is defined (adds the PRESCALE input).
module updown_counter_mod #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic             ENABLE,
    input  logic             DOWN,
    input  logic             SATURATE,
    input  logic             STATUS_CLR,
`ifdef CNT_PRESCALE_EN
    input  logic [7:0]       PRESCALE,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic             STICKY
);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             sticky_reg, sticky_next;
    logic             tick;

`ifdef CNT_PRESCALE_EN
    logic [7:0] div_reg, div_next;

    // Divider advances only while enabled; reaching PRESCALE produces one tick and restarts.
    assign tick = ENABLE && (div_reg == PRESCALE);

    always_comb begin
        div_next = div_reg;
        if (CLEAR || LOAD) begin
            div_next = '0;
        end else if (ENABLE) begin
            div_next = tick ? 8'd0 : div_reg + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end
`else
    assign tick = ENABLE;
`endif

    always_comb begin
        q_next      = q_reg;
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        sticky_next = sticky_reg;
        if (CLEAR) begin
            q_next      = RESET_VAL;
            sticky_next = 1'b0;
        end else begin
            if (LOAD) begin
                q_next = (D > MAX_VAL) ? MAX_VAL : D;
            end else if (tick) begin
                if (!DOWN) begin
                    if (q_reg == MAX_VAL) begin
                        ovf_next = 1'b1;
                        if (!SATURATE) q_next = '0;
                    end else begin
                        q_next = q_reg + WIDTH'(1);
                    end
                end else begin
                    if (q_reg == '0) begin
                        unf_next = 1'b1;
                        if (!SATURATE) q_next = MAX_VAL;
                    end else begin
                        q_next = q_reg - WIDTH'(1);
                    end
                end
            end
            // A new event outranks a simultaneous status clear.
            if (ovf_next || unf_next) begin
                sticky_next = 1'b1;
            end else if (STATUS_CLR) begin
                sticky_next = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg      <= RESET_VAL;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            q_reg      <= q_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            sticky_reg <= sticky_next;
        end
    end

    assign Q         = q_reg;
    assign OVERFLOW  = ovf_reg;
    assign UNDERFLOW = unf_reg;
    assign STICKY    = sticky_reg;
    assign TC        = DOWN ? (q_reg == '0) : (q_reg == MAX_VAL);

endmodule
